// File: rtl/updown_round.sv
// updown_round: single-round controller for the up/down number-guessing game.
// A secret is latched on an accepted start; each rising edge of guess_trigger
// in PLAY grades one guess (UP / DOWN / CORRECT) and consumes one attempt.
// Optional feature macro: UPDOWN_RANGE_HINT_EN. When defined, the live hint
// range [lo_bound, hi_bound] is narrowed after every wrong guess, and guesses
// outside it are rejected without costing an attempt.
module updown_round #(
   parameter int WIDTH     = 7,
   parameter int MAX_VALUE = 99,
   parameter int MAX_TRIES = 7,
   localparam int TW       = $clog2(MAX_TRIES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             guess_trigger,
   input  logic [WIDTH-1:0] user_number,
   input  logic [WIDTH-1:0] actual_number,
   output logic [1:0]       comparison_result,
   output logic             result_valid,
   output logic             guess_rejected,
   output logic [TW-1:0]    tries_left,
   output logic [WIDTH-1:0] lo_bound,
   output logic [WIDTH-1:0] hi_bound,
   output logic             playing,
   output logic             won,
   output logic             lost
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_WIN  = 2'd2,
      S_LOSE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE    = 2'b00,
      RES_UP      = 2'b01,
      RES_DOWN    = 2'b10,
      RES_CORRECT = 2'b11
   } result_t;

   localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
   localparam logic [TW-1:0]    TRIES_INIT = TW'(MAX_TRIES);
   localparam logic [TW-1:0]    ONE_T      = TW'(1);

   state_t           state_q;
   result_t          result_q;
   logic             trig_q;
   logic             valid_q;
   logic [WIDTH-1:0] secret_q;
   logic [TW-1:0]    tries_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_q;

   logic             trig_edge;
   logic             start_ok;
   logic             guess_ok;
   logic             out_of_range;
   result_t          grade_d;

   assign trig_edge = guess_trigger & ~trig_q;
   assign start_ok  = start && (actual_number <= MAX_V);
   assign guess_ok  = trig_edge && (state_q == S_PLAY);

`ifdef UPDOWN_RANGE_HINT_EN
   logic rej_q;
   assign out_of_range   = (user_number < lo_q) || (user_number > hi_q);
   assign guess_rejected = rej_q;
`else
   assign out_of_range   = 1'b0;
   assign guess_rejected = 1'b0;
`endif

   // Grade the presented guess against the latched secret.
   always_comb begin
      // NOTE: default assignment first so every path drives grade_d; no latch is inferred.
      grade_d = RES_DOWN;
      if (user_number == secret_q) begin
         grade_d = RES_CORRECT;
      end else if (user_number < secret_q) begin
         grade_d = RES_UP;
      end
   end

   // Game FSM with registered result, attempt counter and hint range.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
         state_q  <= S_IDLE;
         result_q <= RES_NONE;
         trig_q   <= 1'b0;
         valid_q  <= 1'b0;
         secret_q <= '0;
         tries_q  <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
`ifdef UPDOWN_RANGE_HINT_EN
         rej_q    <= 1'b0;
`endif
      end else begin
         trig_q  <= guess_trigger;
         valid_q <= 1'b0;
`ifdef UPDOWN_RANGE_HINT_EN
         rej_q   <= 1'b0;
`endif
         if (start_ok) begin
            // An accepted start always wins over a simultaneous guess edge.
            secret_q <= actual_number;
            tries_q  <= TRIES_INIT;
            lo_q     <= '0;
            hi_q     <= MAX_V;
            result_q <= RES_NONE;
            state_q  <= S_PLAY;
         end else if (guess_ok) begin
            valid_q <= 1'b1;
            if (out_of_range) begin
               // Outside the hint range: flag it, spend nothing.
               result_q <= RES_NONE;
`ifdef UPDOWN_RANGE_HINT_EN
               rej_q    <= 1'b1;
`endif
            end else begin
               result_q <= grade_d;
               tries_q  <= tries_q - ONE_T;
               if (grade_d == RES_CORRECT) begin
                  state_q <= S_WIN;
               end else begin
`ifdef UPDOWN_RANGE_HINT_EN
                  // Cannot wrap: g < secret <= MAX_VALUE, or g > secret >= 0.
                  if (grade_d == RES_UP) begin
                     lo_q <= user_number + ONE_W;
                  end else begin
                     hi_q <= user_number - ONE_W;
                  end
`endif
                  if (tries_q == ONE_T) begin
                     state_q <= S_LOSE;
                  end
               end
            end
         end
      end
   end

   assign comparison_result = result_q;
   assign result_valid      = valid_q;
   assign tries_left        = tries_q;
   assign lo_bound          = lo_q;
   assign hi_bound          = hi_q;
   assign playing           = (state_q == S_PLAY);
   assign won               = (state_q == S_WIN);
   assign lost              = (state_q == S_LOSE);

endmodule

// File: tb/tb_updown_round.sv
// tb_updown_round: self-checking bench for updown_round. A behavioural game
// model (plain integers) predicts every output after each clock; directed
// scenarios from the game rules are followed by a randomized run.
// Build with or without UPDOWN_RANGE_HINT_EN; the model follows the same macro.
module tb_updown_round;

   localparam int WIDTH     = 7;
   localparam int MAX_VALUE = 99;
   localparam int MAX_TRIES = 7;
   localparam int TW        = $clog2(MAX_TRIES + 1);

`ifdef UPDOWN_RANGE_HINT_EN
   localparam bit RANGE_HINT = 1'b1;
`else
   localparam bit RANGE_HINT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             guess_trigger;
   logic [WIDTH-1:0] user_number;
   logic [WIDTH-1:0] actual_number;
   logic [1:0]       comparison_result;
   logic             result_valid;
   logic             guess_rejected;
   logic [TW-1:0]    tries_left;
   logic [WIDTH-1:0] lo_bound;
   logic [WIDTH-1:0] hi_bound;
   logic             playing;
   logic             won;
   logic             lost;

   updown_round #(
      .WIDTH    (WIDTH),
      .MAX_VALUE(MAX_VALUE),
      .MAX_TRIES(MAX_TRIES)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .guess_trigger    (guess_trigger),
      .user_number      (user_number),
      .actual_number    (actual_number),
      .comparison_result(comparison_result),
      .result_valid     (result_valid),
      .guess_rejected   (guess_rejected),
      .tries_left       (tries_left),
      .lo_bound         (lo_bound),
      .hi_bound         (hi_bound),
      .playing          (playing),
      .won              (won),
      .lost             (lost)
   );

   always #5 clk = ~clk;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Game model: 0 idle, 1 playing, 2 won, 3 lost.
   int m_phase, m_secret, m_tries, m_lo, m_hi, m_res;
   bit m_valid, m_rej, m_prev_trig;
   int pulse_count;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // One clock: drive inputs on the falling edge, advance the model, compare after the rising edge.
   task automatic step(input bit rst, input bit st, input bit trig, input int un, input int an);
      bit rising;
      @(negedge clk);
      reset         = rst;
      start         = st;
      guess_trigger = trig;
      user_number   = WIDTH'(un);
      actual_number = WIDTH'(an);

      rising = trig && !m_prev_trig;
      if (rst) begin
         m_phase = 0; m_secret = 0; m_tries = 0; m_lo = 0; m_hi = 0; m_res = 0;
         m_valid = 0; m_rej = 0; m_prev_trig = 0;
      end else begin
         m_prev_trig = trig;
         m_valid = 0;
         m_rej   = 0;
         if (st && an <= MAX_VALUE) begin
            m_secret = an; m_tries = MAX_TRIES; m_lo = 0; m_hi = MAX_VALUE;
            m_res = 0; m_phase = 1;
         end else if (rising && m_phase == 1) begin
            m_valid = 1;
            if (RANGE_HINT && (un < m_lo || un > m_hi)) begin
               m_rej = 1;
               m_res = 0;
            end else begin
               m_tries = m_tries - 1;
               if (un == m_secret) begin
                  m_res = 3;
                  m_phase = 2;
               end else begin
                  m_res = (un < m_secret) ? 1 : 2;
                  if (RANGE_HINT) begin
                     if (un < m_secret) m_lo = un + 1;
                     else               m_hi = un - 1;
                  end
                  if (m_tries == 0) m_phase = 3;
               end
            end
         end
      end

      @(posedge clk);
      #1;
      check("result", 32'(comparison_result), 32'(m_res));
      check("valid",  32'(result_valid),      32'(m_valid));
      check("reject", 32'(guess_rejected),    32'(m_rej));
      check("tries",  32'(tries_left),        32'(m_tries));
      check("lo",     32'(lo_bound),          32'(m_lo));
      check("hi",     32'(hi_bound),          32'(m_hi));
      check("state",  {29'd0, lost, won, playing},
            32'((m_phase == 1) ? 1 : (m_phase == 2) ? 2 : (m_phase == 3) ? 4 : 0));
      if (result_valid) pulse_count++;
   endtask

   task automatic new_round(input int secret);
      step(0, 1, 0, 0, secret);
      step(0, 0, 0, 0, 0);
   endtask

   task automatic guess(input int g);
      step(0, 0, 1, g, 0);
      step(0, 0, 0, g, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; guess_trigger = 1'b0;
      user_number = '0; actual_number = '0;
      m_prev_trig = 0;

      // Reset state.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("rst_tries", 32'(tries_left), 32'd0);
      check("rst_hi", 32'(hi_bound), 32'd0);

      // Secret 42: guesses 50, 30, 42.
      new_round(42);
      guess(50);
      check("g50_res", 32'(comparison_result), 32'd2);
      check("g50_tries", 32'(tries_left), 32'd6);
      check("g50_hi", 32'(hi_bound), RANGE_HINT ? 32'd49 : 32'd99);
      guess(30);
      check("g30_res", 32'(comparison_result), 32'd1);
      check("g30_lo", 32'(lo_bound), RANGE_HINT ? 32'd31 : 32'd0);
      guess(42);
      check("g42_res", 32'(comparison_result), 32'd3);
      check("g42_tries", 32'(tries_left), 32'd4);
      check("g42_won", 32'(won), 32'd1);
      pulse_count = 0;
      guess(10);
      check("after_win_pulses", 32'(pulse_count), 32'd0);

      // Out-of-range guess after narrowing.
      new_round(42);
      guess(50);
      guess(60);
      check("g60_res", 32'(comparison_result), RANGE_HINT ? 32'd0 : 32'd2);
      check("g60_tries", 32'(tries_left), RANGE_HINT ? 32'd6 : 32'd5);

      // Seven low guesses lose the round.
      new_round(42);
      for (int i = 0; i < 7; i++) guess(i);
      check("lose_tries", 32'(tries_left), 32'd0);
      check("lose_flag", 32'(lost), 32'd1);
      check("lose_res", 32'(comparison_result), 32'd1);

      // Trigger held high for 10 cycles yields one pulse.
      new_round(42);
      pulse_count = 0;
      for (int i = 0; i < 10; i++) step(0, 0, 1, 10, 0);
      step(0, 0, 0, 10, 0);
      check("hold_pulses", 32'(pulse_count), 32'd1);

      // Start and edge together: start wins; then secret 7 confirmed; bad start ignored.
      new_round(42);
      guess(20);
      pulse_count = 0;
      step(0, 1, 1, 7, 7);
      check("start_edge_pulses", 32'(pulse_count), 32'd0);
      check("start_edge_tries", 32'(tries_left), 32'd7);
      step(0, 0, 0, 7, 0);
      guess(7);
      check("secret7_res", 32'(comparison_result), 32'd3);
      step(0, 1, 0, 0, 120);
      check("bad_start_won", 32'(won), 32'd1);

      // Reset mid-round, then edges are ignored until start.
      new_round(42);
      guess(10);
      guess(90);
      step(1, 0, 0, 0, 0);
      check("midrst_playing", 32'(playing), 32'd0);
      pulse_count = 0;
      guess(5);
      guess(6);
      check("midrst_pulses", 32'(pulse_count), 32'd0);

      // Randomized play against the model.
      for (int i = 0; i < 4000; i++) begin
         bit r_rst, r_st, r_trig;
         int r_un, r_an;
         r_rst  = ($urandom_range(0, 199) == 0);
         r_st   = ($urandom_range(0, 39) == 0);
         r_trig = ($urandom_range(0, 2) != 0);
         r_an   = ($urandom_range(0, 5) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 99);
         if (m_phase == 1 && $urandom_range(0, 1) == 1)
            r_un = $urandom_range(m_lo, (m_hi < m_lo) ? m_lo : m_hi);
         else
            r_un = $urandom_range(0, 127);
         step(r_rst, r_st, r_trig, r_un, r_an);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/updown_round.md
# updown_round

Parametrised single-round controller for the up/down number-guessing game. It latches a secret number on `start` and accepts edge-detected guesses. Each accepted guess is graded UP/DOWN/CORRECT against the secret, consumes one attempt, and optionally narrows and enforces a live hint range. It sits between the secret generator and the display/LED logic, replacing the previous fixed-width guess-and-compare path with a complete game FSM.

## Interface
Parameters:
- `WIDTH`, 7: bit width of all numbers.
- `MAX_VALUE`, 99: largest legal secret; initial upper bound. Must be < 2^WIDTH.
- `MAX_TRIES`, 7: attempts per round, ≥1. `TW` = $clog2(MAX_TRIES+1).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level-sampled; begins or restarts a round.
- `guess_trigger` in 1: button level; only its rising edge submits a guess.
- `user_number` in WIDTH: guess value, sampled on the trigger edge.
- `actual_number` in WIDTH: secret, sampled when `start` is accepted.
- `comparison_result` out 2: 00 INVALID/none, 01 UP (guess too low), 10 DOWN (guess too high), 11 CORRECT.
- `result_valid` out 1: one-cycle pulse per graded or rejected guess.
- `guess_rejected` out 1: one-cycle pulse, coincident with `result_valid`, for a rejected guess.
- `tries_left` out TW: remaining attempts.
- `lo_bound`, `hi_bound` out WIDTH each: current hint range.
- `playing`, `won`, `lost` out 1 each: one-hot decode of state; all 0 in IDLE.

## Operation
- FSM states: IDLE, PLAY, WIN, LOSE. Reset → IDLE.
- Edge detect: register `trig_q` ← `guess_trigger` every cycle, in all states. `edge` = `guess_trigger & ~trig_q`. `trig_q` resets to 0.
- `start` accepted in any state when `actual_number` ≤ MAX_VALUE:
  - secret ← `actual_number`; `tries_left` ← MAX_TRIES; `lo_bound` ← 0; `hi_bound` ← MAX_VALUE; `comparison_result` ← 00; next state PLAY.
- `start` with `actual_number` > MAX_VALUE is ignored; state and registers are unchanged.
- `start` and `edge` in the same cycle: `start` wins and the guess is dropped.
- `edge` in PLAY, with g = `user_number`:
  - g == secret: result 11; `tries_left` −1; → WIN.
  - g < secret: result 01; `lo_bound` ← g+1; `tries_left` −1.
  - g > secret: result 10; `hi_bound` ← g−1; `tries_left` −1.
  - Non-correct guess with `tries_left` == 1 before decrement → LOSE (result still 01/10).
- `edge` in IDLE, WIN or LOSE: ignored; no pulse.
- `comparison_result`, bounds and `tries_left` hold until the next update.
- Comparisons are unsigned, full WIDTH. Bound updates cannot wrap: g < secret ≤ MAX_VALUE, and g > secret ≥ 0.

## Timing
- Reset values: `comparison_result` 00, `result_valid` 0, `guess_rejected` 0, `tries_left` 0, `lo_bound` 0, `hi_bound` 0, `playing`/`won`/`lost` 0, state IDLE.
- Latency: if `edge` is seen at clock edge N, result, bounds, `tries_left` and state are all visible after edge N. `result_valid` is high for exactly that one cycle.
- Holding `guess_trigger` high produces one result only. Re-arming needs at least one sampled-low cycle.
- `start` takes effect at the sampling edge; `playing` is 1 the next cycle.
- `reset` mid-round aborts immediately to the reset values; no pulse is generated.
- `start` held high re-initialises every cycle, so guesses are dropped while it is high.

## Configuration
- `UPDOWN_RANGE_HINT_EN` defined:
  - A PLAY guess with g < `lo_bound` or g > `hi_bound` is rejected.
  - Rejection: `result_valid` = 1, `guess_rejected` = 1, `comparison_result` = 00.
  - `tries_left`, bounds and state are unchanged.
- Not defined:
  - Bounds logic is not built; `lo_bound` stays 0 and `hi_bound` stays MAX_VALUE while in PLAY/WIN/LOSE (both 0 after reset until first `start`).
  - Every guess is graded, including guesses > MAX_VALUE. `guess_rejected` is tied to 0.

## Test plan
- Defaults; start with secret 42; guesses 50, 30, 42 → results 10 (hi 49, tries 6), 01 (lo 31, tries 5), 11 (tries 4, `won`=1). A further edge produces no pulse.
- With `UPDOWN_RANGE_HINT_EN`, secret 42, after guess 50: guess 60 → `result_valid`+`guess_rejected`, result 00, `tries_left` stays 6, hi stays 49. Without the macro, guess 60 → result 10, tries 5.
- Secret 42; guesses 0,1,2,3,4,5,6 → each result 01; after the 7th, `tries_left` 0, `lost`=1, last result 01.
- `guess_trigger` held high for 10 cycles with `user_number`=10 → exactly one `result_valid` pulse.
- In PLAY, `start` (secret 7) and a trigger edge in the same cycle → no pulse; tries 7, bounds 0/99, secret 7. Start with secret 120 → ignored.
- `reset` asserted mid-round after two guesses → next cycle all outputs at reset values and state IDLE. Subsequent edges produce no pulse until `start`.
